serial_modadd_ctrl: RTL and testbench

Bit-serial modular adder for NTT butterflies. Computes result = (a + b) mod Q by sequencing one shared single-bit full-adder cell, LSB first, over two passes:
- ADD pass: a + b.
- SUB pass: (a + b) − Q, done as an add of ~Q with carry-in 1.
It then selects the reduced value. This is the area-minimal add path that sits beside the butterfly datapath and is driven by the NTT stage controller through a start/busy/done handshake.

---
 rtl/ntt_pkg.sv | 13 +
 rtl/Full_Adder.sv | 13 +
 rtl/serial_modadd_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_modadd_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants and the controller state encoding for the serial modular adder.
package ntt_pkg;

  localparam int NTT_WIDTH = 14;
  localparam int NTT_Q     = 12289;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } state_t;

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full-adder cell, time-shared by the serial modular adder.
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic Sum
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_modadd_ctrl.sv
// Bit-serial (a + b) mod Q: one full-adder cell, an ADD pass for a+b and a SUB pass
// for (a+b)-Q (add of ~Q with carry-in 1), then the non-negative result is kept.
module serial_modadd_ctrl
  import ntt_pkg::*;
#(
  parameter int WIDTH = NTT_WIDTH,
  parameter int Q     = NTT_Q
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] Q_EXT    = (WIDTH + 1)'(Q);
  localparam logic [CW-1:0]  LAST_ADD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  LAST_SUB = CW'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_sr;
  logic [WIDTH:0]   diff_sr;
  logic [WIDTH:0]   sum_rot;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cout;
  logic             fa_sum;
  logic             add_last;
  logic             sub_last;

  assign add_last = (state == ADD) && (cnt == LAST_ADD);
  assign sub_last = (state == SUB) && (cnt == LAST_SUB);
  // After WIDTH+1 rotations during SUB the sum is back in its original alignment.
  assign sum_rot  = {sum_sr[0], sum_sr[WIDTH:1]};

  Full_Adder u_fa (
    .A    (fa_a),
    .B    (fa_b),
    .Cin  (carry),
    .Cout (fa_cout),
    .Sum  (fa_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = ADD;
      ADD:     if (add_last) state_nxt = SUB;
      SUB:     if (sub_last) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fa_a = 1'b0;
    fa_b = 1'b0;
    case (state)
      ADD: begin
        fa_a = op_a[0];
        fa_b = op_b[0];
      end
      SUB: begin
        fa_a = sum_sr[0];
        fa_b = ~Q_EXT[cnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_sr  <= '0;
      diff_sr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            sum_sr  <= '0;
            diff_sr <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        ADD: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          if (add_last) begin
            // Last sum bit and the carry-out land together so bit 0 ends at sum_sr[0].
            sum_sr <= {fa_cout, fa_sum, sum_sr[WIDTH:2]};
            carry  <= 1'b1;
            cnt    <= '0;
          end else begin
            sum_sr <= {fa_sum, sum_sr[WIDTH:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
          end
        end
        SUB: begin
          sum_sr  <= sum_rot;
          diff_sr <= {fa_sum, diff_sr[WIDTH:1]};
          carry   <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (sub_last) begin
            // Carry-out of sum + ~Q + 1 is set exactly when sum >= Q.
            result <= fa_cout ? diff_sr[WIDTH:1] : sum_rot[WIDTH-1:0];
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_modadd_ctrl.sv
// Directed and back-to-back checks of the bit-serial modular adder against (a+b)%Q.
module tb_serial_modadd_ctrl;

  localparam int WIDTH = 14;
  localparam int Q     = 12289;
  localparam int LAT   = 2 * WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks   = 0;
  int failures = 0;

  serial_modadd_ctrl #(.WIDTH(WIDTH), .Q(Q)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and checks latency, busy profile, result and pulse width.
  task automatic run_op(input string tag, input int va, input int vb, input int exp);
    int lat;
    int busy_bad;
    a     = WIDTH'(va);
    b     = WIDTH'(vb);
    start = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    while (lat < LAT + 10) begin
      tick();
      lat++;
      if (done) break;
      if (!busy) busy_bad++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_result"}, int'(result), exp);
    tick();
    check({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int ndone;
    int cyc;
    int last;
    int va;
    int vb;
    int issued;
    int exp_q[$];

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    rst_n = 1'b1;
    tick();

    run_op("simple", 5, 7, 12);
    run_op("wrap_one", 12288, 1, 0);
    run_op("wrap_max", 12288, 12288, 12287);
    run_op("exact_q", 6000, 6289, 0);
    run_op("zero", 0, 0, 0);

    // Start pulse while busy must be ignored.
    a     = WIDTH'(100);
    b     = WIDTH'(200);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    a     = WIDTH'(1);
    b     = WIDTH'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        ndone++;
        check("busy_start_result", int'(result), 300);
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_idle", int'(busy), 0);

    // Reset during the SUB pass.
    a     = WIDTH'(500);
    b     = WIDTH'(600);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_result", int'(result), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midreset_no_done", ndone, 0);
    run_op("after_reset", 3, 4, 7);

    // Back-to-back with start held high.
    va = int'($urandom_range(Q - 1));
    vb = int'($urandom_range(Q - 1));
    a  = WIDTH'(va);
    b  = WIDTH'(vb);
    exp_q.push_back((va + vb) % Q);
    issued = 1;
    start  = 1'b1;
    ndone  = 0;
    cyc    = 0;
    last   = 0;
    while (ndone < 1000 && cyc < 1000 * 30 + 200) begin
      tick();
      cyc++;
      if (done) begin
        ndone++;
        check("b2b_spacing", cyc - last, 30);
        check("b2b_result", int'(result), exp_q.pop_front());
        last = cyc;
        if (issued < 1000) begin
          va = int'($urandom_range(Q - 1));
          vb = int'($urandom_range(Q - 1));
          a  = WIDTH'(va);
          b  = WIDTH'(vb);
          exp_q.push_back((va + vb) % Q);
          issued++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_done_total", ndone, 1000);
    repeat (3) tick();
    check("final_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
